// File: rtl/ram_wb_bridge_pkg.sv
// ram_wb_bridge_pkg
//   Shared definitions for ram_wb_bridge: FSM state encoding and the
//   number of byte lanes per 32-bit Wishbone word.
package ram_wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam int unsigned LANES = 4;

endpackage

// File: rtl/ram_wb_bridge.sv
// ram_wb_bridge
//   Bridges a 32-bit Wishbone slave port onto an 8-bit dual-port RAM
//   (write port 0, synchronous read port 1). Each request is serialised
//   into four byte-lane accesses; all outputs are registered.
//
//   Optional feature: define RAM_WB_BRIDGE_RDBUF_EN to add a one-word read
//   buffer that answers a repeated read of the same word in one cycle.
//
//   Ports
//     clk, reset          clock, asynchronous active-high reset
//     i_wb_adr/dat/sel/we Wishbone request (byte address, bits [1:0] unused)
//     i_wb_cyc            request valid
//     o_wb_rdt, o_wb_ack  read data, one-cycle completion strobe
//     o_csb0/addr0/din0   RAM write port (select active-low)
//     o_csb1/addr1        RAM read port (select active-low)
//     i_dout1             RAM read data, one cycle after address
module ram_wb_bridge
  import ram_wb_bridge_pkg::*;
#(
  parameter int unsigned aw = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [aw-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_csb0,
  output logic [aw-1:0] o_addr0,
  output logic [7:0]    o_din0,
  output logic          o_csb1,
  output logic [aw-1:0] o_addr1,
  input  logic [7:0]    i_dout1
);

  localparam int unsigned WAW = aw - 2;
  localparam logic [1:0]  K_LAST = 2'(LANES - 1);

  state_t          state_q;
  logic [1:0]      k_q;
  logic            tail_q;      // READ: all addresses issued, last byte pending
  logic [WAW-1:0]  adr_q;
  logic [31:0]     dat_q;
  logic [3:0]      sel_q;
  logic [23:0]     rbuf_q;      // lanes 0..2 collected before completion
  logic [31:0]     rdt_q;
  logic            ack_q;
  logic            csb0_q;
  logic [aw-1:0]   addr0_q;
  logic [7:0]      din0_q;
  logic            csb1_q;
  logic [aw-1:0]   addr1_q;

  logic [1:0]      k_inc;
  logic [1:0]      k_dec;
  logic            rd_hit;
  logic            unused_adr;

  assign k_inc      = k_q + 2'd1;
  assign k_dec      = k_q - 2'd1;
  assign unused_adr = &{1'b0, i_wb_adr[1:0]};

`ifdef RAM_WB_BRIDGE_RDBUF_EN
  // Buffer data is o_wb_rdt itself: it holds exactly the last completed
  // read, which is the word the buffer describes.
  logic           rbv_q;
  logic [WAW-1:0] rbtag_q;

  assign rd_hit = ~i_wb_we & rbv_q & (rbtag_q == i_wb_adr[aw-1:2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbv_q   <= 1'b0;
      rbtag_q <= '0;
    end else if (state_q == ST_READ && tail_q) begin
      rbv_q   <= 1'b1;
      rbtag_q <= adr_q;
    end else if (state_q == ST_IDLE && i_wb_cyc && i_wb_we &&
                 rbtag_q == i_wb_adr[aw-1:2]) begin
      rbv_q   <= 1'b0;
    end
  end
`else
  assign rd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      tail_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rbuf_q  <= '0;
      rdt_q   <= '0;
      ack_q   <= 1'b0;
      csb0_q  <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
      csb1_q  <= 1'b1;
      addr1_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_wb_cyc) begin
            adr_q  <= i_wb_adr[aw-1:2];
            dat_q  <= i_wb_dat;
            sel_q  <= i_wb_sel;
            k_q    <= '0;
            tail_q <= 1'b0;
            if (rd_hit) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else if (i_wb_we) begin
              state_q <= ST_WRITE;
              csb0_q  <= ~i_wb_sel[0];
              addr0_q <= {i_wb_adr[aw-1:2], 2'b00};
              din0_q  <= i_wb_dat[7:0];
            end else begin
              state_q <= ST_READ;
              csb1_q  <= 1'b0;
              addr1_q <= {i_wb_adr[aw-1:2], 2'b00};
            end
          end
        end

        ST_WRITE: begin
          if (k_q == K_LAST) begin
            csb0_q  <= 1'b1;
            state_q <= ST_ACK;
            ack_q   <= i_wb_cyc;
          end else begin
            k_q     <= k_inc;
            csb0_q  <= ~sel_q[k_inc];
            addr0_q <= {adr_q, k_inc};
            din0_q  <= dat_q[{k_inc, 3'b000} +: 8];
          end
        end

        // Addresses go out for lanes 0..3; each byte returns one cycle
        // later, so capture trails issue by one and a tail cycle collects
        // lane 3 before completing.
        ST_READ: begin
          if (tail_q) begin
            rdt_q   <= {i_dout1, rbuf_q};
            state_q <= ST_ACK;
            ack_q   <= i_wb_cyc;
          end else begin
            if (k_q != 2'd0) rbuf_q[{k_dec, 3'b000} +: 8] <= i_dout1;
            if (k_q == K_LAST) begin
              csb1_q <= 1'b1;
              tail_q <= 1'b1;
            end else begin
              k_q     <= k_inc;
              addr1_q <= {adr_q, k_inc};
            end
          end
        end

        ST_ACK: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_csb0   = csb0_q;
  assign o_addr0  = addr0_q;
  assign o_din0   = din0_q;
  assign o_csb1   = csb1_q;
  assign o_addr1  = addr1_q;

endmodule

// File: tb/tb_ram_wb_bridge.sv
module tb_ram_wb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        csb0, csb1;
  logic [9:0]  addr0, addr1;
  logic [7:0]  din0;
  logic [7:0]  dout1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_wb_bridge #(.aw(10)) dut (
    .clk(clk), .reset(reset),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc),
    .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .o_csb0(csb0), .o_addr0(addr0), .o_din0(din0),
    .o_csb1(csb1), .o_addr1(addr1), .i_dout1(dout1)
  );

  // Attached dual-port RAM: synchronous write, one-cycle registered read.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (!csb0) ram[addr0] <= din0;
    if (!csb1) dout1 <= ram[addr1];
  end

  // Transaction-level reference model.
  logic [7:0] exp_mem [0:1023];
  logic       mdl_bv;
  logic [7:0] mdl_btag;
`ifdef RAM_WB_BRIDGE_RDBUF_EN
  localparam bit RDBUF = 1'b1;
`else
  localparam bit RDBUF = 1'b0;
`endif

  task automatic model(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic we, output int e_lat, output int e_c0, output int e_c1,
                       output logic [3:0] e_lanes, output logic [31:0] e_rdt);
    logic hit;
    e_rdt = '0;
    if (we) begin
      e_lat = 5; e_c1 = 0; e_lanes = s; e_c0 = $countones(s);
      for (int i = 0; i < 4; i++)
        if (s[i]) exp_mem[{a[9:2], 2'(i)}] = d[8*i +: 8];
      if (mdl_bv && mdl_btag == a[9:2]) mdl_bv = 1'b0;
    end else begin
      hit = RDBUF && mdl_bv && (mdl_btag == a[9:2]);
      e_rdt = {exp_mem[{a[9:2], 2'd3}], exp_mem[{a[9:2], 2'd2}],
               exp_mem[{a[9:2], 2'd1}], exp_mem[{a[9:2], 2'd0}]};
      e_lat = hit ? 1 : 6; e_c1 = hit ? 0 : 4; e_c0 = 0; e_lanes = '0;
      if (!hit) begin mdl_bv = 1'b1; mdl_btag = a[9:2]; end
    end
  endtask

  // Drives one request in cycle T and observes cycles T+1..T+10. cyc is held
  // through the ack cycle and dropped the cycle after, or at cycle drop_at.
  task automatic run_txn(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic we, input int drop_at,
                         output int ack_n, output int acks, output int c0,
                         output logic [3:0] c0_lanes, output int c1, output int c1_first,
                         output int c1_last, output logic [31:0] rdt);
    logic prev_ack;
    @(posedge clk); #1;
    wb_adr = a; wb_dat = d; wb_sel = s; wb_we = we; wb_cyc = 1'b1;
    ack_n = -1; acks = 0; c0 = 0; c0_lanes = '0; c1 = 0; c1_first = -1; c1_last = -1;
    rdt = '0; prev_ack = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (prev_ack || n == drop_at) wb_cyc = 1'b0;
      prev_ack = 1'b0;
      if (wb_ack) begin
        acks++;
        if (ack_n < 0) begin ack_n = n; rdt = wb_rdt; end
        prev_ack = 1'b1;
      end
      if (!csb0) begin c0++; if (n <= 4) c0_lanes[n-1] = 1'b1; end
      if (!csb1) begin c1++; if (c1_first < 0) c1_first = n; c1_last = n; end
    end
    wb_cyc = 1'b0;
  endtask

  int ack_n, acks, c0, c1, c1f, c1l;
  logic [3:0] c0l;
  logic [31:0] rdt;
  int e_lat, e_c0, e_c1;
  logic [3:0] e_lanes;
  logic [31:0] e_rdt;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 7;
    if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", wb_ack); end
    if (wb_rdt !== 32'h0) begin n_fail++; $display("FAIL reset_rdt got %h want 0", wb_rdt); end
    if (csb0 !== 1'b1) begin n_fail++; $display("FAIL reset_csb0 got %b want 1", csb0); end
    if (csb1 !== 1'b1) begin n_fail++; $display("FAIL reset_csb1 got %b want 1", csb1); end
    if (addr0 !== 10'h0) begin n_fail++; $display("FAIL reset_addr0 got %h want 0", addr0); end
    if (addr1 !== 10'h0) begin n_fail++; $display("FAIL reset_addr1 got %h want 0", addr1); end
    if (din0 !== 8'h0) begin n_fail++; $display("FAIL reset_din0 got %h want 0", din0); end
    reset = 1'b0;
  endtask

  task automatic test_write_full();
    logic [31:0] got;
    model(10'h010, 32'hA1B2C3D4, 4'hF, 1'b1, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h010, 32'hA1B2C3D4, 4'hF, 1'b1, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    got = {ram[10'h013], ram[10'h012], ram[10'h011], ram[10'h010]};
    n_cmp += 4;
    if (got !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL wr_full_mem got %h want a1b2c3d4", got); end
    if (ack_n !== 5) begin n_fail++; $display("FAIL wr_full_lat got %0d want 5", ack_n); end
    if (acks !== 1) begin n_fail++; $display("FAIL wr_full_acks got %0d want 1", acks); end
    if (c0l !== 4'hF) begin n_fail++; $display("FAIL wr_full_lanes got %b want 1111", c0l); end
  endtask

  task automatic test_write_sel();
    logic [7:0] keep1, keep3;
    keep1 = exp_mem[10'h021]; keep3 = exp_mem[10'h023];
    model(10'h020, 32'h11223344, 4'h5, 1'b1, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h020, 32'h11223344, 4'h5, 1'b1, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 6;
    if (ram[10'h020] !== 8'h44) begin n_fail++; $display("FAIL wr_sel_b0 got %h want 44", ram[10'h020]); end
    if (ram[10'h022] !== 8'h22) begin n_fail++; $display("FAIL wr_sel_b2 got %h want 22", ram[10'h022]); end
    if (ram[10'h021] !== keep1) begin n_fail++; $display("FAIL wr_sel_b1 got %h want %h", ram[10'h021], keep1); end
    if (ram[10'h023] !== keep3) begin n_fail++; $display("FAIL wr_sel_b3 got %h want %h", ram[10'h023], keep3); end
    if (c0l !== 4'b0101) begin n_fail++; $display("FAIL wr_sel_lanes got %b want 0101", c0l); end
    if (ack_n !== 5) begin n_fail++; $display("FAIL wr_sel_lat got %0d want 5", ack_n); end
  endtask

  task automatic test_write_nosel();
    model(10'h024, $urandom, 4'h0, 1'b1, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h024, 32'hDEADBEEF, 4'h0, 1'b1, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 2;
    if (c0 !== 0) begin n_fail++; $display("FAIL wr_nosel_csb0 got %0d want 0", c0); end
    if (ack_n !== 5) begin n_fail++; $display("FAIL wr_nosel_lat got %0d want 5", ack_n); end
  endtask

  task automatic test_read();
    model(10'h010, '0, 4'h1, 1'b0, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h010, '0, 4'h1, 1'b0, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 6;
    if (rdt !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL rd_data got %h want a1b2c3d4", rdt); end
    if (ack_n !== 6) begin n_fail++; $display("FAIL rd_lat got %0d want 6", ack_n); end
    if (acks !== 1) begin n_fail++; $display("FAIL rd_acks got %0d want 1", acks); end
    if (c1 !== 4) begin n_fail++; $display("FAIL rd_csb1_cnt got %0d want 4", c1); end
    if (c1f !== 1) begin n_fail++; $display("FAIL rd_csb1_first got %0d want 1", c1f); end
    if (c1l !== 4) begin n_fail++; $display("FAIL rd_csb1_last got %0d want 4", c1l); end
  endtask

  // Repeat read, intervening write to the same word, read again.
  task automatic test_back_to_back();
    logic [31:0] d;
    model(10'h010, '0, 4'hF, 1'b0, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h010, '0, 4'hF, 1'b0, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 3;
    if (ack_n !== e_lat) begin n_fail++; $display("FAIL b2b_rd2_lat got %0d want %0d", ack_n, e_lat); end
    if (c1 !== e_c1) begin n_fail++; $display("FAIL b2b_rd2_csb1 got %0d want %0d", c1, e_c1); end
    if (rdt !== e_rdt) begin n_fail++; $display("FAIL b2b_rd2_data got %h want %h", rdt, e_rdt); end
    d = $urandom;
    model(10'h012, d, 4'hF, 1'b1, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h012, d, 4'hF, 1'b1, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    model(10'h010, '0, 4'hF, 1'b0, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h010, '0, 4'hF, 1'b0, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 3;
    if (ack_n !== 6) begin n_fail++; $display("FAIL b2b_rd3_lat got %0d want 6", ack_n); end
    if (c1 !== 4) begin n_fail++; $display("FAIL b2b_rd3_csb1 got %0d want 4", c1); end
    if (rdt !== e_rdt) begin n_fail++; $display("FAIL b2b_rd3_data got %h want %h", rdt, e_rdt); end
  endtask

  task automatic test_cyc_drop();
    logic [31:0] d;
    d = $urandom;
    model(10'h040, d, 4'hF, 1'b1, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h040, d, 4'hF, 1'b1, 2, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 2;
    if (acks !== 0) begin n_fail++; $display("FAIL drop_wr_acks got %0d want 0", acks); end
    if (c0 !== 4) begin n_fail++; $display("FAIL drop_wr_csb0 got %0d want 4", c0); end
    model(10'h040, '0, 4'hF, 1'b0, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h040, '0, 4'hF, 1'b0, 3, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 2;
    if (acks !== 0) begin n_fail++; $display("FAIL drop_rd_acks got %0d want 0", acks); end
    if (c1 !== 4) begin n_fail++; $display("FAIL drop_rd_csb1 got %0d want 4", c1); end
    model(10'h044, '0, 4'hF, 1'b0, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h044, '0, 4'hF, 1'b0, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 2;
    if (ack_n !== 6) begin n_fail++; $display("FAIL drop_next_lat got %0d want 6", ack_n); end
    if (rdt !== e_rdt) begin n_fail++; $display("FAIL drop_next_data got %h want %h", rdt, e_rdt); end
  endtask

  task automatic test_reset_mid();
    int bad_ack, bad_sel;
    @(posedge clk); #1;
    wb_adr = 10'h030; wb_dat = 32'h55667788; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;          // T+1
    @(posedge clk); #1;          // T+2
    reset = 1'b1;
    #1;
    n_cmp += 2;
    if (csb0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_csb0 got %b want 1", csb0); end
    if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack got %b want 0", wb_ack); end
    wb_cyc = 1'b0;
    exp_mem[10'h030] = 8'h88;    // only lane 0 completed before reset
    mdl_bv = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bad_ack = 0; bad_sel = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (wb_ack) bad_ack++;
      if (!csb0 || !csb1) bad_sel++;
    end
    n_cmp += 2;
    if (bad_ack !== 0) begin n_fail++; $display("FAIL rstmid_late_ack got %0d want 0", bad_ack); end
    if (bad_sel !== 0) begin n_fail++; $display("FAIL rstmid_late_sel got %0d want 0", bad_sel); end
    model(10'h030, 32'h0BADF00D, 4'hF, 1'b1, e_lat, e_c0, e_c1, e_lanes, e_rdt);
    run_txn(10'h030, 32'h0BADF00D, 4'hF, 1'b1, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
    n_cmp += 1;
    if (ack_n !== 5) begin n_fail++; $display("FAIL rstmid_next_lat got %0d want 5", ack_n); end
  endtask

  task automatic test_random();
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        we;
    for (int i = 0; i < 40; i++) begin
      a  = 10'h100 + 10'($urandom_range(0, 15));
      d  = $urandom;
      s  = 4'($urandom);
      we = 1'($urandom);
      model(a, d, s, we, e_lat, e_c0, e_c1, e_lanes, e_rdt);
      run_txn(a, d, s, we, 0, ack_n, acks, c0, c0l, c1, c1f, c1l, rdt);
      n_cmp += 4;
      if (ack_n !== e_lat) begin n_fail++; $display("FAIL rnd%0d_lat got %0d want %0d", i, ack_n, e_lat); end
      if (acks !== 1) begin n_fail++; $display("FAIL rnd%0d_acks got %0d want 1", i, acks); end
      if (c0l !== e_lanes || c0 !== e_c0) begin
        n_fail++; $display("FAIL rnd%0d_csb0 got %b/%0d want %b/%0d", i, c0l, c0, e_lanes, e_c0);
      end
      if (c1 !== e_c1) begin n_fail++; $display("FAIL rnd%0d_csb1 got %0d want %0d", i, c1, e_c1); end
      if (!we) begin
        n_cmp++;
        if (rdt !== e_rdt) begin n_fail++; $display("FAIL rnd%0d_data got %h want %h", i, rdt, e_rdt); end
      end
    end
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== exp_mem[i]) bad++;
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL mem_image got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0;
    dout1 = '0;
    mdl_bv = 1'b0; mdl_btag = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    test_reset();
    test_write_full();
    test_write_sel();
    test_write_nosel();
    test_read();
    test_back_to_back();
    test_cyc_drop();
    test_reset_mid();
    test_random();
    test_mem_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_wb_bridge.md
RAM_WB_BRIDGE -- requirements
Module: ram_wb_bridge

Interface
REQ-001 SHALL have parameter aw, default 10, byte-address width of the attached 8-bit dual-port RAM.
REQ-002 SHALL have ports:
  clk  in  1  sole clock, all logic on posedge
  reset  in  1  asynchronous, active-high
  i_wb_adr  in  aw  Wishbone byte address; bits [1:0] ignored
  i_wb_dat  in  32  write data
  i_wb_sel  in  4  byte lane enables
  i_wb_we  in  1  1 = write
  i_wb_cyc  in  1  request valid
  o_wb_rdt  out  32  read data
  o_wb_ack  out  1  one-cycle completion strobe
  o_csb0  out  1  RAM write-port select, active-low
  o_addr0  out  aw  RAM write address
  o_din0  out  8  RAM write data
  o_csb1  out  1  RAM read-port select, active-low
  o_addr1  out  aw  RAM read address
  i_dout1  in  8  RAM read data
REQ-003 All outputs SHALL be registered.

Function
REQ-004 FSM states IDLE, WRITE, READ, ACK; lane counter k of 2 bits.
REQ-005 IDLE with i_wb_cyc=1 in cycle T: latch adr/dat/sel/we, k=0, go to WRITE (we=1) or READ (we=0).
REQ-006 WRITE: cycles T+1..T+4 present lane k=0..3: o_addr0={adr[aw-1:2],k}, o_din0=dat[8k+7:8k], o_csb0=~sel[k].
REQ-007 READ: cycles T+1..T+4 present o_csb1=0, o_addr1={adr[aw-1:2],k}; all 4 lanes read regardless of sel.
REQ-008 Read latency: lane k's i_dout1 is sampled at the posedge ending cycle T+2+k into o_wb_rdt[8k+7:8k].
REQ-009 o_wb_ack SHALL be high exactly one cycle: T+5 for writes, T+6 for reads; then IDLE.
REQ-010 Outside active lanes o_csb0=o_csb1=1, o_addr0/o_addr1/o_din0 hold last values.
REQ-011 Request accepted only in IDLE; i_wb_cyc still high during the ack cycle SHALL NOT start a new transaction.
REQ-012 i_wb_cyc dropped mid-transaction: RAM sequence completes unchanged; ack suppressed if i_wb_cyc=0 in ack cycle; FSM still returns to IDLE.
REQ-013 i_wb_sel=0 write: full 4-cycle sequence, no o_csb0 low, ack still at T+5.
REQ-014 o_wb_rdt SHALL hold its value until the next read completion.

Reset
REQ-015 reset=1 SHALL immediately force IDLE, k=0, o_wb_ack=0, o_wb_rdt=0, o_csb0=o_csb1=1, o_addr0=o_addr1=0, o_din0=0.
REQ-016 Reset mid-transaction SHALL abort without ack; no further RAM selects after reset asserts.

Configuration
REQ-017 Macro RAM_WB_BRIDGE_RDBUF_EN defined: one-word read buffer (valid, tag=adr[aw-1:2], 32-bit data) filled on each read completion.
REQ-018 With RDBUF: read accepted in T hitting valid tag goes directly to ACK, ack at T+1 with buffered data, no RAM access.
REQ-019 With RDBUF: any accepted write whose tag matches clears valid; reset clears valid.
REQ-020 Macro undefined: no buffer logic; every read takes REQ-007..009 timing.

Structure
REQ-021 Shared package ram_wb_bridge_pkg SHALL hold the FSM state encoding and lane-count constant (4).
REQ-022 No sub-module; single flat module.

Verification
REQ-023 Write adr=0x010, dat=0xA1B2C3D4, sel=0xF -> RAM bytes 0x010..0x013 = D4,C3,B2,A1; ack at T+5.
REQ-024 Write adr=0x020, sel=0x5, dat=0x11223344 -> only 0x020=44, 0x022=22 written; o_csb0 high in lanes 1,3.
REQ-025 Read back adr=0x010 -> o_wb_rdt=0xA1B2C3D4, ack at T+6, o_csb1 low T+1..T+4.
REQ-026 Reset asserted at T+2 of a write -> ack never asserted, o_csb0=1 immediately, next request accepted normally.
REQ-027 RDBUF: two consecutive reads of 0x010 -> second acks at T+1, no o_csb1 activity; intervening write to 0x012 forces full-latency read.
REQ-028 i_wb_cyc held high through ack -> exactly one ack, no second RAM sequence.
